// File: rtl/sipo_deser_pkg.sv
// ---------------------------------------------------------------------------
// sipo_deser_pkg
// Shared definitions for the serial-to-parallel receiver:
//   - state_e : receive FSM states (HUNT for a start marker, COLLECT bits)
//   - cnt_w() : width of the bit counter for an N-bit word
// ---------------------------------------------------------------------------
package sipo_deser_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    // Counter only has to reach N-1; it wraps to 0 on completion.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : sipo_deser_pkg

// File: rtl/sipo_deser_if.sv
// ---------------------------------------------------------------------------
// sipo_deser_if
// Parallel valid/ready word interface between the receiver and downstream.
//   par_out   : assembled word, stable while out_valid=1
//   out_valid : par_out holds an undelivered word
//   out_ready : downstream accepts the word when out_valid && out_ready
// Modports: master = word producer (receiver), slave = word consumer.
// ---------------------------------------------------------------------------
interface sipo_deser_if #(
    parameter int N = 8
);
    logic [N-1:0] par_out;
    logic         out_valid;
    logic         out_ready;

    modport master (output par_out, output out_valid, input out_ready);
    modport slave  (input par_out, input out_valid, output out_ready);

endinterface : sipo_deser_if

// File: rtl/sipo_hold_reg.sv
// ---------------------------------------------------------------------------
// sipo_hold_reg
// One-word valid/ready holding register.
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   load_req_i  : a completed word is offered this cycle
//   word_i      : the offered word
//   accepted_o  : with load_req_i, 1 = word loaded, 0 = word dropped
//   out_if      : parallel valid/ready interface (master side)
// The register is free when empty or when its word is taken this cycle, so
// a drain and a load may happen on the same edge.
// ---------------------------------------------------------------------------
module sipo_hold_reg #(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_req_i,
    input  logic [N-1:0]    word_i,
    output logic            accepted_o,
    sipo_deser_if.master    out_if
);

    logic [N-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         take;
    logic         free;

    assign take       = valid_q && out_if.out_ready;
    assign free       = !valid_q || take;
    assign accepted_o = load_req_i && free;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (take) begin
            valid_d = 1'b0;          // par_out keeps its last value
        end
        if (accepted_o) begin
            valid_d = 1'b1;
            data_d  = word_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_if.par_out   = data_q;
    assign out_if.out_valid = valid_q;

endmodule : sipo_hold_reg

// File: rtl/sipo_deser.sv
// ---------------------------------------------------------------------------
// sipo_deser
// Serial-to-parallel receiver. A word starts with a bit flagged frame_start,
// collects N bits, and is handed to a one-word holding register presented
// on a valid/ready interface. Overrun and framing errors are sticky.
// Ports:
//   clk, reset   : clock, synchronous active-low reset
//   bit_valid    : data_in / frame_start are sampled this cycle
//   data_in      : serial data bit
//   frame_start  : current bit is the first bit of a word
//   out_if       : par_out / out_valid / out_ready (master side)
//   overrun      : sticky, a completed word was dropped
//   frame_err    : sticky, frame_start arrived mid-word
//   clear_err    : clears both sticky flags (a same-cycle set wins)
// Parameters:
//   N         : word width (>= 2)
//   MSB_FIRST : 1 = first bit lands in par_out[N-1], 0 = in par_out[0]
// ---------------------------------------------------------------------------
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            bit_valid,
    input  logic            data_in,
    input  logic            frame_start,
    sipo_deser_if.master    out_if,
    output logic            overrun,
    output logic            frame_err,
    input  logic            clear_err
);

    localparam int           CW   = cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  shift_q, shift_d;
    logic [N-1:0]  shift_in;    // shift_q with data_in shifted in
    logic [N-1:0]  first_word;  // empty register with data_in as bit 0
    logic          overrun_q, frame_err_q;
    logic          load_req;
    logic          accepted;
    logic          fe_set;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shift_in   = {shift_q[N-2:0], data_in};
            assign first_word = {{(N-1){1'b0}}, data_in};
        end else begin : g_lsb
            assign shift_in   = {data_in, shift_q[N-1:1]};
            assign first_word = {data_in, {(N-1){1'b0}}};
        end
    endgenerate

    // Next-state: framing, shifting and word completion.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        load_req = 1'b0;
        fe_set   = 1'b0;
        if (bit_valid) begin
            if (frame_start) begin
                // A marker inside a word abandons the partial word.
                fe_set  = (state_q == COLLECT);
                state_d = COLLECT;
                cnt_d   = CW'(1);
                shift_d = first_word;
            end else if (state_q == COLLECT) begin
                shift_d = shift_in;
                if (cnt_q == LAST) begin
                    load_req = 1'b1;
                    state_d  = HUNT;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            shift_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            // Set has priority over clear.
            overrun_q   <= (overrun_q && !clear_err) || (load_req && !accepted);
            frame_err_q <= (frame_err_q && !clear_err) || fe_set;
        end
    end

    // The completed word is shift_in, so par_out is valid the edge the
    // last bit is sampled.
    sipo_hold_reg #(.N(N)) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load_req_i (load_req),
        .word_i     (shift_in),
        .accepted_o (accepted),
        .out_if     (out_if)
    );

    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule : sipo_deser
